display_arbiter: RTL and testbench

// Shares the single 4-digit 7-segment display driver between N_SRC requesters
// (operand A/B, sum, status word, ...). Rotates round-robin with a fixed dwell

---
 rtl/disp_pkg.sv | 17 +
 rtl/rr_pick.sv | 34 +++
 rtl/display_arbiter.sv | 137 +++++++++++++
 tb/tb_display_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared constants and state encoding for the display arbiter.
// Sizes the 4-digit hex bus and its blank mask.
package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHOW   = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    localparam int DIGITS   = 4;
    localparam int NIBBLE_W = 4;
    localparam int DISP_W   = DIGITS * NIBBLE_W;

    localparam logic [DIGITS-1:0] BLANK_ALL = 4'hF;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first requester after `last`,
// scanning last+1 .. last+N_SRC modulo N_SRC.
module rr_pick #(
    parameter int N_SRC = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] next_idx,
    output logic             found
);

    // Scan from the farthest offset down so the nearest requester wins.
    function automatic logic [IDX_W:0] search(input logic [N_SRC-1:0] r,
                                              input logic [IDX_W-1:0] l);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] cand;
        res = '0;
        for (int off = N_SRC; off >= 1; off--) begin
            cand = IDX_W'((int'(l) + off) % N_SRC);
            if (r[cand]) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

    logic [IDX_W:0] result;

    assign result   = search(req, last);
    assign found    = result[IDX_W];
    assign next_idx = result[IDX_W-1:0];

endmodule

// File: rtl/display_arbiter.sv
// Round-robin sharing of one 4-digit 7-segment driver between N_SRC sources,
// with fixed dwell, pin (hold) and manual advance. All outputs registered.
module display_arbiter
    import disp_pkg::*;
#(
    parameter int N_SRC        = 4,
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int CNT_W        = 26
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_SRC-1:0]          req,
    input  logic [DISP_W*N_SRC-1:0]   src_data,
    input  logic                      pin,
    input  logic                      next_btn,
    output logic [DISP_W-1:0]         digit_out,
    output logic [DIGITS-1:0]         blank_out,
    output logic [N_SRC-1:0]          grant,
    output logic                      busy
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_INIT  = IDX_W'(N_SRC - 1);
    localparam logic [N_SRC-1:0] ONE_HOT0   = N_SRC'(1);

    if (N_SRC < 2 || N_SRC > 8) begin : g_bad_nsrc
        $error("display_arbiter: N_SRC must be 2..8");
    end
    if (DWELL_CYCLES < 1 || longint'(DWELL_CYCLES) > (longint'(1) << CNT_W)) begin : g_bad_dwell
        $error("display_arbiter: DWELL_CYCLES must be 1..2**CNT_W");
    end

    logic [DISP_W-1:0] src_arr [N_SRC];

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        assign src_arr[i] = src_data[DISP_W*i +: DISP_W];
    end

    state_t            state_r;
    logic [IDX_W-1:0]  last_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [DISP_W-1:0] digit_r;
    logic [DIGITS-1:0] blank_r;
    logic [N_SRC-1:0]  grant_r;
    logic              busy_r;

    logic [IDX_W-1:0]  pick_idx_s;
    logic              pick_found_s;
    logic              others_req_s;

    rr_pick #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req      (req),
        .last     (last_r),
        .next_idx (pick_idx_s),
        .found    (pick_found_s)
    );

    assign others_req_s = |(req & ~grant_r);

    // FSM, dwell counter and registered display outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            last_r  <= LAST_INIT;
            cnt_r   <= '0;
            digit_r <= 16'h0000;
            blank_r <= BLANK_ALL;
            grant_r <= '0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    digit_r <= 16'h0000;
                    blank_r <= BLANK_ALL;
                    grant_r <= '0;
                    busy_r  <= 1'b0;
                    if (|req) begin
                        state_r <= ST_SWITCH;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                // Display holds its last value here so changeover never flashes.
                ST_SWITCH: begin
                    if (pick_found_s) begin
                        grant_r <= ONE_HOT0 << pick_idx_s;
                        last_r  <= pick_idx_s;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= ST_SHOW;
                    end else begin
                        grant_r <= '0;
                        blank_r <= BLANK_ALL;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHOW: begin
                    digit_r <= src_arr[last_r];
                    blank_r <= 4'h0;
                    if (!req[last_r]) begin
                        state_r <= ST_SWITCH;
                    end else if (next_btn) begin
                        state_r <= ST_SWITCH;
                    end else if (!pin && cnt_r == DWELL_LAST) begin
                        cnt_r <= '0;
                        if (others_req_s) begin
                            state_r <= ST_SWITCH;
                        end else begin
                            state_r <= ST_SHOW;
                        end
                    end else if (!pin) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    grant_r <= '0;
                    blank_r <= BLANK_ALL;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign digit_out = digit_r;
    assign blank_out = blank_r;
    assign grant     = grant_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed self-checking bench for display_arbiter (N_SRC=4, DWELL_CYCLES=8).
// Each task drives one scenario and compares against hand-derived cycle timing.
module tb_display_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] src [4];
    logic [63:0] src_data;
    logic        pin;
    logic        next_btn;
    logic [15:0] digit_out;
    logic [3:0]  blank_out;
    logic [3:0]  grant;
    logic        busy;

    int checks;
    int failures;

    assign src_data = {src[3], src[2], src[1], src[0]};

    display_arbiter #(
        .N_SRC        (4),
        .DWELL_CYCLES (8),
        .CNT_W        (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .src_data  (src_data),
        .pin       (pin),
        .next_btn  (next_btn),
        .digit_out (digit_out),
        .blank_out (blank_out),
        .grant     (grant),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req = 4'b1111;
        do_reset();
        step(12);
        checks++;
        if (grant !== 4'b0010) begin
            failures++;
            $display("FAIL pre_reset_grant got=%b exp=%b", grant, 4'b0010);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (digit_out !== 16'h0000 || blank_out !== 4'hF || grant !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got digit=%h blank=%h grant=%b busy=%b exp 0000/F/0000/0",
                     digit_out, blank_out, grant, busy);
        end
        rst = 1'b0;
        step(2);
        checks++;
        if (grant !== 4'b0001 || busy !== 1'b1) begin
            failures++;
            $display("FAIL first_grant got grant=%b busy=%b exp 0001/1", grant, busy);
        end
        step(1);
        checks++;
        if (blank_out !== 4'h0 || digit_out !== 16'h1234) begin
            failures++;
            $display("FAIL first_show got blank=%h digit=%h exp 0/1234", blank_out, digit_out);
        end
    endtask

    task automatic test_alternate();
        logic [3:0]  exp_g;
        logic [15:0] exp_d;
        req = 4'b0101;
        do_reset();
        step(2);
        checks++;
        if (grant !== 4'b0001) begin
            failures++;
            $display("FAIL alt_grant0 got=%b exp=0001", grant);
        end
        for (int s = 3; s <= 40; s++) begin
            step(1);
            exp_g = (((s - 2) / 9) % 2 == 0) ? 4'b0001 : 4'b0100;
            exp_d = (((s - 3) / 9) % 2 == 0) ? 16'h1234 : 16'hABCD;
            checks++;
            if (grant !== exp_g || digit_out !== exp_d || blank_out !== 4'h0) begin
                failures++;
                $display("FAIL alt_cycle%0d got grant=%b digit=%h blank=%h exp %b/%h/0",
                         s, grant, digit_out, blank_out, exp_g, exp_d);
            end
        end
    endtask

    task automatic test_sole();
        req = 4'b0010;
        src[1] = 16'h5555;
        do_reset();
        step(2);
        for (int s = 3; s <= 28; s++) begin
            step(1);
            checks++;
            if (grant !== 4'b0010 || blank_out !== 4'h0 || digit_out !== 16'h5555) begin
                failures++;
                $display("FAIL sole_cycle%0d got grant=%b blank=%h digit=%h exp 0010/0/5555",
                         s, grant, blank_out, digit_out);
            end
        end
        src[1] = 16'h00FF;
        step(1);
        checks++;
        if (digit_out !== 16'h00FF) begin
            failures++;
            $display("FAIL sole_live_data got=%h exp=00FF", digit_out);
        end
    endtask

    task automatic test_pin();
        req = 4'b0011;
        do_reset();
        step(2);
        pin = 1'b1;
        for (int s = 0; s < 30; s++) begin
            step(1);
            checks++;
            if (grant !== 4'b0001) begin
                failures++;
                $display("FAIL pin_hold%0d got=%b exp=0001", s, grant);
            end
        end
        next_btn = 1'b1;
        step(1);
        next_btn = 1'b0;
        checks++;
        if (grant !== 4'b0001) begin
            failures++;
            $display("FAIL btn_switch_gap got=%b exp=0001", grant);
        end
        step(1);
        checks++;
        if (grant !== 4'b0010) begin
            failures++;
            $display("FAIL btn_advance got=%b exp=0010", grant);
        end
        pin = 1'b0;
    endtask

    task automatic test_wrap();
        req = 4'b1000;
        do_reset();
        step(2);
        req = 4'b1001;
        step(3);
        checks++;
        if (grant !== 4'b1000) begin
            failures++;
            $display("FAIL wrap_on_src3 got=%b exp=1000", grant);
        end
        req = 4'b0001;
        step(1);
        checks++;
        if (grant !== 4'b1000) begin
            failures++;
            $display("FAIL wrap_gap got=%b exp=1000", grant);
        end
        step(1);
        checks++;
        if (grant !== 4'b0001) begin
            failures++;
            $display("FAIL wrap_grant got=%b exp=0001", grant);
        end
        step(2);
        req = 4'b0000;
        step(2);
        checks++;
        if (grant !== 4'b0000 || blank_out !== 4'hF || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_entry got grant=%b blank=%h busy=%b exp 0000/F/0",
                     grant, blank_out, busy);
        end
        step(3);
        checks++;
        if (grant !== 4'b0000 || blank_out !== 4'hF || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold got grant=%b blank=%h busy=%b exp 0000/F/0",
                     grant, blank_out, busy);
        end
    endtask

    task automatic test_btn_in_switch();
        req = 4'b0101;
        do_reset();
        step(1);
        next_btn = 1'b1;
        step(1);
        next_btn = 1'b0;
        for (int s = 2; s <= 10; s++) begin
            checks++;
            if (grant !== 4'b0001) begin
                failures++;
                $display("FAIL btn_ignored_cycle%0d got=%b exp=0001", s, grant);
            end
            step(1);
        end
        checks++;
        if (grant !== 4'b0100) begin
            failures++;
            $display("FAIL full_dwell_after_btn got=%b exp=0100", grant);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        req      = 4'b0000;
        pin      = 1'b0;
        next_btn = 1'b0;
        src[0]   = 16'h1234;
        src[1]   = 16'h5555;
        src[2]   = 16'hABCD;
        src[3]   = 16'h3333;
        test_reset();
        test_alternate();
        test_sole();
        test_pin();
        test_wrap();
        test_btn_in_switch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
